// File: rtl/matmul_result_requant.sv
// matmul_result_requant
// Requantisation stage behind the matrix-multiply array. Each lane of an
// incoming accumulator row receives a per-column bias, a rounding arithmetic
// right shift, optional ReLU and saturation to the output width. Finished
// rows queue in a small FIFO with ready/valid toward writeback. The producer
// cannot be stalled, so a row arriving at a full FIFO is dropped and a
// sticky overflow flag is raised.
module matmul_result_requant #(
    parameter int ARRAY_SIZE  = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SHIFT_WIDTH-1:0]          cfg_shift,
    input  logic                            cfg_relu,
    input  logic                            bias_we,
    input  logic [$clog2(ARRAY_SIZE)-1:0]   bias_idx,
    input  logic [ACC_WIDTH-1:0]            bias_data,
    input  logic                            in_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0] out_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [15:0]                     sat_count
);

    localparam int SUM_W  = ACC_WIDTH + 1;
    localparam int EXT_W  = ACC_WIDTH + 2;
    localparam int ROW_W  = ARRAY_SIZE * OUT_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SATI_W = $clog2(ARRAY_SIZE + 1);
    localparam int SATC_W = 16;

    localparam logic signed [EXT_W-1:0] OUT_MAX  = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN  = {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] EXT_ONE  = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic signed [EXT_W-1:0] EXT_ZERO = {EXT_W{1'b0}};
    localparam logic [SHIFT_WIDTH-1:0]  SHIFT_ZERO = {SHIFT_WIDTH{1'b0}};
    localparam logic [SHIFT_WIDTH-1:0]  SHIFT_ONE  = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]        PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]        PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Bias registers
    logic [ACC_WIDTH-1:0]    bias_r [ARRAY_SIZE];

    // Stage 1 registers: biased sums plus the config captured with the row
    logic                    s1_valid_r;
    logic [SUM_W-1:0]        s1_sum_r [ARRAY_SIZE];
    logic [SHIFT_WIDTH-1:0]  s1_shift_r;
    logic                    s1_relu_r;

    // Stage 1 combinational
    logic [ACC_WIDTH-1:0]    acc_lane_s [ARRAY_SIZE];
    logic [SUM_W-1:0]        s1_sum_s   [ARRAY_SIZE];

    // Stage 2 combinational
    logic signed [EXT_W-1:0] ext_s     [ARRAY_SIZE];
    logic signed [EXT_W-1:0] round_s   [ARRAY_SIZE];
    logic signed [EXT_W-1:0] shifted_s [ARRAY_SIZE];
    logic signed [EXT_W-1:0] relu_s    [ARRAY_SIZE];
    logic signed [EXT_W-1:0] clamp_s   [ARRAY_SIZE];
    logic                    lane_sat_s [ARRAY_SIZE];
    logic [SATI_W-1:0]       sat_inc_s;
    logic [ROW_W-1:0]        row_s;
    logic [SATC_W:0]         sat_sum_s;

    // FIFO state
    logic [ROW_W-1:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic [CNT_W-1:0]        count_next_s;
    logic                    out_valid_r;
    logic                    overflow_r;
    logic [SATC_W-1:0]       sat_count_r;
    logic                    pop_s;
    logic                    push_ok_s;

    // Bias register file; a row in the same cycle still sees the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                bias_r[j] <= {ACC_WIDTH{1'b0}};
            end
        end else if (bias_we) begin
            bias_r[bias_idx] <= bias_data;
        end
    end

    // Stage 1 sum: sign-extend both operands by one bit so the add cannot overflow
    always_comb begin
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            acc_lane_s[j] = in_data[j*ACC_WIDTH +: ACC_WIDTH];
            s1_sum_s[j]   = {acc_lane_s[j][ACC_WIDTH-1], acc_lane_s[j]}
                          + {bias_r[j][ACC_WIDTH-1], bias_r[j]};
        end
    end

    // Stage 1 register: capture sums and the config that belongs to this row
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_shift_r <= SHIFT_ZERO;
            s1_relu_r  <= 1'b0;
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                s1_sum_r[j] <= {SUM_W{1'b0}};
            end
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_shift_r <= cfg_shift;
                s1_relu_r  <= cfg_relu;
                for (int j = 0; j < ARRAY_SIZE; j++) begin
                    s1_sum_r[j] <= s1_sum_s[j];
                end
            end
        end
    end

    // Stage 2: round half-up, shift, ReLU, clamp; count clamped lanes
    always_comb begin
        sat_inc_s = {SATI_W{1'b0}};
        row_s     = {ROW_W{1'b0}};
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            ext_s[j] = {s1_sum_r[j][SUM_W-1], s1_sum_r[j]};
            if (s1_shift_r != SHIFT_ZERO) begin
                round_s[j] = EXT_ONE << (s1_shift_r - SHIFT_ONE);
            end else begin
                round_s[j] = EXT_ZERO;
            end
            shifted_s[j] = (ext_s[j] + round_s[j]) >>> s1_shift_r;
            if (s1_relu_r && (shifted_s[j] < EXT_ZERO)) begin
                relu_s[j] = EXT_ZERO;
            end else begin
                relu_s[j] = shifted_s[j];
            end
            if (relu_s[j] > OUT_MAX) begin
                clamp_s[j]    = OUT_MAX;
                lane_sat_s[j] = 1'b1;
            end else if (relu_s[j] < OUT_MIN) begin
                clamp_s[j]    = OUT_MIN;
                lane_sat_s[j] = 1'b1;
            end else begin
                clamp_s[j]    = relu_s[j];
                lane_sat_s[j] = 1'b0;
            end
            row_s[j*OUT_WIDTH +: OUT_WIDTH] = clamp_s[j][OUT_WIDTH-1:0];
            sat_inc_s = sat_inc_s + {{(SATI_W-1){1'b0}}, lane_sat_s[j]};
        end
        sat_sum_s = {1'b0, sat_count_r} + {{(SATC_W+1-SATI_W){1'b0}}, sat_inc_s};
    end

    // FIFO control: a full FIFO still accepts a write when the head pops on the same edge
    always_comb begin
        pop_s     = (count_r != CNT_ZERO) && out_ready;
        push_ok_s = s1_valid_r && ((count_r != CNT_FULL) || pop_s);
        case ({push_ok_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {ROW_W{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= row_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != CNT_ZERO);
            if (s1_valid_r && !push_ok_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Saturation event counter, itself saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_r <= {SATC_W{1'b0}};
        end else if (s1_valid_r) begin
            if (sat_sum_s[SATC_W]) begin
                sat_count_r <= {SATC_W{1'b1}};
            end else begin
                sat_count_r <= sat_sum_s[SATC_W-1:0];
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = mem_r[rd_ptr_r];
    assign fifo_count = count_r;
    assign overflow   = overflow_r;
    assign sat_count  = sat_count_r;

endmodule
